// File: rtl/cmp_window_stats_if.sv
// Sample stream and summary-record handshake for cmp_window_stats.
// The slave modport belongs to the block. The master modport belongs to the comparator side and the record consumer.
interface cmp_window_stats_if #(
   parameter int CNT_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic             lt;
   logic             eq;
   logic             gt;
   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] n_lt;
   logic [CNT_W-1:0] n_eq;
   logic [CNT_W-1:0] n_gt;
   logic [CNT_W-1:0] n_bad;
   logic [CNT_W-1:0] max_run;

   modport slave (
      input  in_valid, lt, eq, gt, out_ready,
      output in_ready, out_valid, n_lt, n_eq, n_gt, n_bad, max_run
   );

   modport master (
      output in_valid, lt, eq, gt, out_ready,
      input  in_ready, out_valid, n_lt, n_eq, n_gt, n_bad, max_run
   );
endinterface

// File: rtl/cmp_window_stats.sv
// Tallies comparator lt/eq/gt results over WIN_LEN-sample windows and emits one summary record per window.
// Define CMP_RUN_TRACK_EN to build longest-run tracking. Without it, max_run is tied to 0.
//
// state | meaning
// ACCUM | accepting samples; a completed window goes straight to the output slot if it is free
// FULL  | completed window parked in the accumulators, waiting for the output slot to drain
module cmp_window_stats #(
   parameter int WIN_LEN = 8,
   parameter int CNT_W   = 4
) (
   input logic                clk,
   input logic                rst,
   cmp_window_stats_if.slave  bus
);
   typedef enum logic {ACCUM, FULL} state_t;

   localparam logic [CNT_W-1:0] WIN_END = CNT_W'(WIN_LEN);

   state_t state, state_nxt;
   logic   accept, legal, win_end, slot_free, load_new, load_old;

   logic [CNT_W-1:0] acc_lt, acc_eq, acc_gt, acc_bad, sample_cnt;
   logic [CNT_W-1:0] nxt_lt, nxt_eq, nxt_gt, nxt_bad, nxt_cnt;
   logic [CNT_W-1:0] out_lt, out_eq, out_gt, out_bad;

   // One-hot iff an odd number of flags is set and not all three are set.
   assign legal  = (bus.lt ^ bus.eq ^ bus.gt) && !(bus.lt && bus.eq && bus.gt);
   assign accept = bus.in_valid && bus.in_ready;

   assign nxt_lt  = acc_lt  + CNT_W'(legal && bus.lt);
   assign nxt_eq  = acc_eq  + CNT_W'(legal && bus.eq);
   assign nxt_gt  = acc_gt  + CNT_W'(legal && bus.gt);
   assign nxt_bad = acc_bad + CNT_W'(!legal);
   assign nxt_cnt = sample_cnt + 1'b1;

   assign win_end   = accept && (nxt_cnt == WIN_END);
   assign slot_free = !bus.out_valid || bus.out_ready;

`ifdef CMP_RUN_TRACK_EN
   logic [1:0]       cls, prev_class, nxt_prev;
   logic [CNT_W-1:0] cur_run, acc_max_run, nxt_run, nxt_max, out_max_run;

   // Class code 0 means "no previous legal result", so an illegal sample breaks any run.
   always_comb begin
      cls      = bus.lt ? 2'd1 : (bus.eq ? 2'd2 : 2'd3);
      nxt_prev = 2'd0;
      nxt_run  = '0;
      if (legal) begin
         nxt_prev = cls;
         if (sample_cnt != '0 && cls == prev_class) nxt_run = cur_run + 1'b1;
         else                                        nxt_run = CNT_W'(1);
      end
      nxt_max = (nxt_run > acc_max_run) ? nxt_run : acc_max_run;
   end

   assign bus.max_run = out_max_run;
`else
   assign bus.max_run = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= ACCUM;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM: if (win_end && !slot_free)             state_nxt = FULL;
         FULL:  if (bus.out_valid && bus.out_ready)    state_nxt = ACCUM;
         default:                                      state_nxt = ACCUM;
      endcase
   end

   always_comb begin
      bus.in_ready = !rst && (state == ACCUM);
      load_new     = (state == ACCUM) && win_end && slot_free;
      load_old     = (state == FULL) && bus.out_valid && bus.out_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         {out_lt, out_eq, out_gt, out_bad}         <= '0;
         {acc_lt, acc_eq, acc_gt, acc_bad}         <= '0;
         sample_cnt                                <= '0;
`ifdef CMP_RUN_TRACK_EN
         {cur_run, acc_max_run, out_max_run}       <= '0;
         prev_class                                <= 2'd0;
`endif
      end else begin
         bus.out_valid <= load_new || load_old || (bus.out_valid && !bus.out_ready);
         if (load_new) begin
            {out_lt, out_eq, out_gt, out_bad} <= {nxt_lt, nxt_eq, nxt_gt, nxt_bad};
`ifdef CMP_RUN_TRACK_EN
            out_max_run <= nxt_max;
`endif
         end else if (load_old) begin
            {out_lt, out_eq, out_gt, out_bad} <= {acc_lt, acc_eq, acc_gt, acc_bad};
`ifdef CMP_RUN_TRACK_EN
            out_max_run <= acc_max_run;
`endif
         end
         if (load_new || load_old) begin
            {acc_lt, acc_eq, acc_gt, acc_bad} <= '0;
            sample_cnt                        <= '0;
`ifdef CMP_RUN_TRACK_EN
            {cur_run, acc_max_run}            <= '0;
            prev_class                        <= 2'd0;
`endif
         end else if (accept) begin
            {acc_lt, acc_eq, acc_gt, acc_bad} <= {nxt_lt, nxt_eq, nxt_gt, nxt_bad};
            sample_cnt                        <= nxt_cnt;
`ifdef CMP_RUN_TRACK_EN
            cur_run     <= nxt_run;
            acc_max_run <= nxt_max;
            prev_class  <= nxt_prev;
`endif
         end
      end
   end

   assign bus.n_lt  = out_lt;
   assign bus.n_eq  = out_eq;
   assign bus.n_gt  = out_gt;
   assign bus.n_bad = out_bad;
endmodule

// File: tb/tb_cmp_window_stats.sv
// Scoreboard bench for cmp_window_stats: directed windows followed by random traffic with random back-pressure.
module tb_cmp_window_stats;
   localparam int WIN_LEN = 8;
   localparam int CNT_W   = 4;

   typedef struct {
      int n_lt;
      int n_eq;
      int n_gt;
      int n_bad;
      int run;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   bit   rst_prev = 1'b0;
   bit   done = 1'b0;

   rec_t       exp_q[$];
   logic [2:0] win[$];
   logic [2:0] last_f = 3'b100;

   cmp_window_stats_if #(.CNT_W(CNT_W)) bus ();

   cmp_window_stats #(.WIN_LEN(WIN_LEN), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // The record for a window: class counts, and the longest stretch of equal legal results.
   function automatic rec_t summarize();
      rec_t r;
      r = '{0, 0, 0, 0, 0};
      for (int i = 0; i < win.size(); i++) begin
         if ($countones(win[i]) != 1) r.n_bad++;
         else if (win[i][2])          r.n_lt++;
         else if (win[i][1])          r.n_eq++;
         else                         r.n_gt++;
      end
`ifdef CMP_RUN_TRACK_EN
      for (int i = 0; i < win.size(); i++) begin
         int len = 0;
         if ($countones(win[i]) == 1)
            while (i + len < win.size() && win[i + len] == win[i]) len++;
         if (len > r.run) r.run = len;
      end
`endif
      return r;
   endfunction

   // Reference model and monitor. Sampling happens mid low phase, while handshake inputs are stable.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            chk("in_ready_in_reset", int'(bus.in_ready), 0);
            exp_q.delete();
            win.delete();
            rst_prev = 1'b1;
         end else begin
            bit exp_rdy;
            exp_rdy = exp_q.size() < 2;
            if (rst_prev) begin
               chk("rst_n_lt", int'(bus.n_lt), 0);
               chk("rst_n_eq", int'(bus.n_eq), 0);
               chk("rst_n_gt", int'(bus.n_gt), 0);
               chk("rst_n_bad", int'(bus.n_bad), 0);
               chk("rst_max_run", int'(bus.max_run), 0);
            end
            chk("out_valid", int'(bus.out_valid), int'(exp_q.size() != 0));
            chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
            if (bus.out_valid && exp_q.size() != 0) begin
               chk("n_lt", int'(bus.n_lt), exp_q[0].n_lt);
               chk("n_eq", int'(bus.n_eq), exp_q[0].n_eq);
               chk("n_gt", int'(bus.n_gt), exp_q[0].n_gt);
               chk("n_bad", int'(bus.n_bad), exp_q[0].n_bad);
               chk("max_run", int'(bus.max_run), exp_q[0].run);
               chk("sum", int'(bus.n_lt) + int'(bus.n_eq) + int'(bus.n_gt) + int'(bus.n_bad), WIN_LEN);
               if (bus.out_ready) void'(exp_q.pop_front());
            end
            if (bus.in_valid && exp_rdy) begin
               win.push_back({bus.lt, bus.eq, bus.gt});
               if (win.size() == WIN_LEN) begin
                  exp_q.push_back(summarize());
                  win.delete();
               end
            end
            rst_prev = 1'b0;
         end
      end
   end

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // Presents one sample and holds it until the block is ready. The sample is taken on the next rising edge.
   task automatic push_sample(input logic [2:0] f);
      int n = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      {bus.lt, bus.eq, bus.gt} = f;
      #2;
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (n >= 200) chk("accept_timeout", 0, 1);
   endtask

   function automatic logic [2:0] rand_flags();
      int r;
      logic [2:0] f;
      r = $urandom_range(0, 15);
      if (r < 6)       f = last_f;
      else if (r < 13) f = 3'b001 << $urandom_range(0, 2);
      else             f = 3'($urandom_range(0, 7));
      last_f = f;
      return f;
   endfunction

   initial begin
      logic [2:0] pat1[8] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b001, 3'b010, 3'b010};
      logic [2:0] pat2[8] = '{3'b010, 3'b010, 3'b000, 3'b010, 3'b110, 3'b010, 3'b010, 3'b010};
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      {bus.lt, bus.eq, bus.gt} = 3'b000;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      foreach (pat1[i]) push_sample(pat1[i]);
      idle();
      #2;
      chk("t1_out_valid", int'(bus.out_valid), 1);
      chk("t1_n_lt", int'(bus.n_lt), 3);
      chk("t1_n_eq", int'(bus.n_eq), 3);
      chk("t1_n_gt", int'(bus.n_gt), 2);
      chk("t1_n_bad", int'(bus.n_bad), 0);
`ifdef CMP_RUN_TRACK_EN
      chk("t1_max_run", int'(bus.max_run), 3);
`else
      chk("t1_max_run", int'(bus.max_run), 0);
`endif

      foreach (pat2[i]) push_sample(pat2[i]);
      idle();
      #2;
      chk("t2_n_bad", int'(bus.n_bad), 2);
      chk("t2_n_eq", int'(bus.n_eq), 6);
`ifdef CMP_RUN_TRACK_EN
      chk("t2_max_run", int'(bus.max_run), 3);
`endif
      idle();

      // Two windows against a stalled consumer, then flags offered while FULL.
      bus.out_ready = 1'b0;
      repeat (16) push_sample(rand_flags());
      idle();
      #2;
      chk("t3_full_in_ready", int'(bus.in_ready), 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         {bus.lt, bus.eq, bus.gt} = 3'(i + 3);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      #2;
      chk("t3_exit_in_ready", int'(bus.in_ready), 1);
      chk("t3_exit_out_valid", int'(bus.out_valid), 1);

      // Window end coincides with draining the pending record.
      repeat (7) push_sample(rand_flags());
      @(negedge clk);
      bus.in_valid  = 1'b1;
      {bus.lt, bus.eq, bus.gt} = 3'b001;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      #2;
      chk("t4_no_bubble", int'(bus.out_valid), 1);
      @(negedge clk);
      bus.out_ready = 1'b1;
      repeat (2) idle();

      // Reset with a record pending and a partial window.
      bus.out_ready = 1'b0;
      repeat (13) push_sample(rand_flags());
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #2;
      chk("t5_out_valid", int'(bus.out_valid), 0);
      bus.out_ready = 1'b1;
      foreach (pat1[i]) push_sample(pat1[i]);
      idle();
      #2;
      chk("t5_n_lt", int'(bus.n_lt), 3);

      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) idle();
               push_sample(rand_flags());
            end
            idle();
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               bus.out_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join

      bus.out_ready = 1'b1;
      begin
         int n = 0;
         while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (n >= 50) chk("drain_timeout", 0, 1);
      end
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
